// File: rtl/display7seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment patterns are the active-low base form; polarity is applied at the pins.
package display7seg_pkg;

    localparam int DIGITS     = 8;
    localparam int BCD_DIGITS = 10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_e;

    function automatic logic [6:0] dec2seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/display7seg_scan_ctrl_if.sv
// Value load handshake plus the display pin bundle.
interface display7seg_scan_ctrl_if;
    logic [31:0] valor;
    logic        valor_valid;
    logic        ready;
    logic        done;
    logic        ovf;
    logic [6:0]  seg;
    logic [7:0]  an;

    modport master (output valor, valor_valid, input ready, done, ovf, seg, an);
    modport slave  (input valor, valor_valid, output ready, done, ovf, seg, an);
endinterface

// File: rtl/display7seg_scan_ctrl_bin_to_bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, 32 steps per value.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] din,
    output logic        finish,
    output logic [39:0] result
);
    import display7seg_pkg::*;

    logic [31:0] sr_q, sr_d;
    logic [39:0] acc_q, acc_d;
    logic [4:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic [39:0] adj;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;

        sr_d   = sr_q;
        acc_d  = acc_q;
        step_d = step_q;
        busy_d = busy_q;
        if (start) begin
            sr_d   = din;
            acc_d  = '0;
            step_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {acc_d, sr_d} = {adj, sr_q} << 1;
            step_d        = step_q + 5'd1;
            if (step_q == 5'd31) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            acc_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    // Asserted during the last step; result is final on the following cycle.
    assign finish = busy_q && (step_q == 5'd31);
    assign result = acc_q;

endmodule

// File: rtl/display7seg_scan_ctrl.sv
// Load FSM, committed display register and the digit scanner driving one
// shared segment bus across eight digit enables.
module display7seg_scan_ctrl #(
    parameter bit COMMON_ANODE = 1'b0,
    parameter int CLK_DIV      = 50000,
    parameter bit BLANK_LZ     = 1'b1
) (
    input logic               clk,
    input logic               rst,
    display7seg_scan_ctrl_if.slave bus
);
    import display7seg_pkg::*;

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [6:0]        SEG_RST = COMMON_ANODE ? ~dec2seg(4'd0) : dec2seg(4'd0);
    localparam logic [DIGITS-1:0] AN_ONE  = {{(DIGITS-1){1'b0}}, 1'b1};
    localparam logic [DIGITS-1:0] AN_RST  = COMMON_ANODE ? AN_ONE : ~AN_ONE;

    state_e                  state_q, state_d;
    logic [DIGITS-1:0][3:0]  disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [DIGITS-1:0]       an_q, an_d;

    logic        start;
    logic        finish;
    logic [39:0] bcd;

    bin_to_bcd_seq u_bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (bus.valor),
        .finish (finish),
        .result (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valor_valid) state_d = CONVERT;
            CONVERT: if (finish)          state_d = LOAD;
            LOAD:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        start  = 1'b0;
        disp_d = disp_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: start = bus.valor_valid;
            LOAD: begin
                done_d = 1'b1;
                // Digits above the eighth mean the value cannot be shown.
                if (bcd[39:32] != 8'd0) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d  = 1'b0;
                    disp_d = bcd[31:0];
                end
            end
            default: ;
        endcase
    end

    logic [DIGITS-1:0] nz_above;
    logic [6:0]        pat;

    always_comb begin
        logic any_nz;
        any_nz = 1'b0;
        for (int i = DIGITS-1; i >= 0; i--) begin
            any_nz      = any_nz | (disp_q[i] != 4'd0);
            nz_above[i] = any_nz;
        end

        if (presc_q == PW'(CLK_DIV-1)) begin
            presc_d = '0;
            idx_d   = idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end

        if (ovf_q)                                        pat = SEG_DASH;
        else if (BLANK_LZ && idx_q != '0 && !nz_above[idx_q]) pat = SEG_BLANK;
        else                                              pat = dec2seg(disp_q[idx_q]);

        seg_d = COMMON_ANODE ? ~pat : pat;
        an_d  = COMMON_ANODE ? (AN_ONE << idx_q) : ~(AN_ONE << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_RST;
            an_q    <= AN_RST;
        end else begin
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.seg   = seg_q;
    assign bus.an    = an_q;

endmodule

// File: tb/tb_display7seg_scan_ctrl.sv
// Directed bench: a common-cathode unit under test plus a common-anode twin
// fed the same stimulus, whose pins must always be the bitwise inverse.
module tb_display7seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display7seg_scan_ctrl_if if1();
    display7seg_scan_ctrl_if if2();
    assign if2.valor       = if1.valor;
    assign if2.valor_valid = if1.valor_valid;

    display7seg_scan_ctrl #(.COMMON_ANODE(1'b0), .CLK_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(if1));
    display7seg_scan_ctrl #(.COMMON_ANODE(1'b1), .CLK_DIV(4), .BLANK_LZ(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .bus(if2));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (if1.done === 1'b1) done_cnt++;
        check("inv_seg", {25'd0, if2.seg}, {25'd0, ~if1.seg});
        check("inv_an",  {24'd0, if2.an},  {24'd0, ~if1.an});
    endtask

    // Digit codes: 0-9 numerals, A = dash, B = blank.
    function automatic logic [6:0] pat(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic load(input logic [31:0] v);
        int n;
        n = 0;
        while (if1.ready !== 1'b1 && n < 100) begin tick(); n++; end
        check("ready_before_load", {31'd0, if1.ready}, 32'd1);
        if1.valor = v;
        if1.valor_valid = 1'b1;
        tick();
        if1.valor_valid = 1'b0;
        check("ready_low_after_accept", {31'd0, if1.ready}, 32'd0);
        n = 0;
        while (if1.done !== 1'b1 && n < 100) begin tick(); n++; end
        check("done_latency", n, 32'd33);
        tick();
        check("done_one_cycle", {31'd0, if1.done}, 32'd0);
        check("ready_after_load", {31'd0, if1.ready}, 32'd1);
    endtask

    task automatic scan_check(input string tag, input logic [31:0] codes);
        int idx, prev, run, chg;
        logic [7:0] a, seen;
        prev = -1; run = 0; chg = 0; seen = '0; idx = 0;
        repeat (40) begin
            a = ~if1.an;
            check({tag, "_an_onehot"}, $countones(a), 32'd1);
            for (int i = 0; i < 8; i++) if (a[i]) idx = i;
            seen[idx] = 1'b1;
            check({tag, "_seg"}, {25'd0, if1.seg}, {25'd0, pat(codes[4*idx +: 4])});
            if (idx != prev) begin
                if (chg >= 2) check({tag, "_dwell"}, run, 32'd4);
                chg++;
                run = 1;
                prev = idx;
            end else begin
                run++;
            end
            tick();
        end
        check({tag, "_all_digits"}, {24'd0, seen}, 32'hFF);
    endtask

    initial begin
        int n, d0, c1;
        if1.valor = '0;
        if1.valor_valid = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("rst_ready", {31'd0, if1.ready}, 32'd1);
            check("rst_ovf",   {31'd0, if1.ovf},   32'd0);
            check("rst_an",    {24'd0, if1.an},    32'hFE);
            check("rst_seg",   {25'd0, if1.seg},   32'h40);
            check("rst_done",  {31'd0, if1.done},  32'd0);
        end

        load(32'd12345678);
        check("ovf_12345678", {31'd0, if1.ovf}, 32'd0);
        scan_check("d12345678", 32'h12345678);

        load(32'd99999999);
        check("ovf_99999999", {31'd0, if1.ovf}, 32'd0);
        scan_check("d99999999", 32'h99999999);

        load(32'd100000000);
        check("ovf_100000000", {31'd0, if1.ovf}, 32'd1);
        scan_check("dash", 32'hAAAAAAAA);
        check("ovf_sticky", {31'd0, if1.ovf}, 32'd1);

        load(32'd305);
        check("ovf_cleared", {31'd0, if1.ovf}, 32'd0);
        scan_check("d305", 32'hBBBBB305);

        load(32'd0);
        scan_check("d0", 32'hBBBBBBB0);

        // Requests during a conversion are dropped.
        d0 = done_cnt;
        if1.valor = 32'd42;
        if1.valor_valid = 1'b1;
        tick();
        if1.valor_valid = 1'b0;
        repeat (4) tick();
        if1.valor = 32'd7;
        if1.valor_valid = 1'b1;
        check("busy_ready_t5", {31'd0, if1.ready}, 32'd0);
        tick();
        if1.valor_valid = 1'b0;
        repeat (4) tick();
        if1.valor_valid = 1'b1;
        tick();
        if1.valor_valid = 1'b0;
        repeat (30) tick();
        check("ignore_done_count", done_cnt - d0, 32'd1);
        scan_check("d42", 32'hBBBBBB42);

        // Held valid gives a load every 34 cycles.
        if1.valor = 32'd12345678;
        if1.valor_valid = 1'b1;
        n = 0;
        while (if1.done !== 1'b1 && n < 100) begin tick(); n++; end
        check("held_first_done", {31'd0, if1.done}, 32'd1);
        repeat (2) begin
            c1 = cyc;
            tick();
            n = 0;
            while (if1.done !== 1'b1 && n < 100) begin tick(); n++; end
            check("held_period", cyc - c1, 32'd34);
        end
        if1.valor_valid = 1'b0;
        repeat (40) tick();

        // Reset in the middle of a conversion.
        if1.valor = 32'hFFFFFFFF;
        if1.valor_valid = 1'b1;
        tick();
        if1.valor_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = done_cnt;
        tick();
        check("midrst_ready", {31'd0, if1.ready}, 32'd1);
        check("midrst_ovf",   {31'd0, if1.ovf},   32'd0);
        scan_check("midrst_disp", 32'hBBBBBBB0);
        check("midrst_no_done", done_cnt - d0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display7seg_scan_ctrl.md
# display7seg_scan_ctrl

Sequenced driver for an 8-digit multiplexed seven-segment display. It accepts a 32-bit binary value through a valid/ready handshake and converts it to BCD iteratively, one double-dabble step per clock. It then commits the digits to a display register and time-multiplexes one shared segment bus across eight digit enables. It sits between any value producer (counter, CPU register tap) and the board pins, and replaces a per-digit flat decode where the board exposes only one segment bus.

## Interface
- COMMON_ANODE, 0: output polarity select; 0 passes base patterns, 1 inverts `seg` and `an`.
- CLK_DIV, 50000: clock cycles each digit stays enabled; legal range ≥1.
- BLANK_LZ, 1: when 1, leading zeros above the most significant nonzero digit are blanked; digit 0 is always shown.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- valor  in  32  unsigned binary value to display.
- valor_valid  in  1  request to load `valor`.
- ready  out  1  high when a new value can be accepted (IDLE).
- done  out  1  one-cycle pulse when the display register is updated.
- ovf  out  1  sticky until next load; high if the last value exceeded 99,999,999.
- seg  out  7  segment bus {g,f,e,d,c,b,a}.
- an  out  8  one-hot digit enable, bit i = digit i (0 = least significant).

## Operation
- Base segment patterns are active-low (0 = lit): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Blank→1111111, dash→0111111.
- Base `an` is active-low: the selected digit is 0 and the rest are 1. With COMMON_ANODE=1, both `seg` and `an` are bitwise inverted.
- FSM states are IDLE, CONVERT and LOAD. `ready` = (state==IDLE).
- IDLE: when `valor_valid` is high, capture `valor` into a 32-bit shift register, clear the 40-bit BCD accumulator (10 digits), clear the step counter, and go to CONVERT.
- `valor_valid` is ignored outside IDLE. No queueing.
- CONVERT: each cycle, add 3 to every accumulator nibble that is ≥5. Then shift {accumulator, shift register} left by 1. After 32 steps (step counter 31→wrap), go to LOAD.
- LOAD: if accumulator[39:32] ≠ 0, set `ovf`=1 and show all eight digits as dash. Otherwise set `ovf`=0 and copy accumulator[31:0] into the display register. Pulse `done`, then return to IDLE.
- Scanner, independent of the FSM:
  - A prescaler counts 0..CLK_DIV−1. At terminal count the digit index increments 0..7 and wraps 7→0.
  - `seg` = pattern of display digit[index], or blank if BLANK_LZ and the digit is a leading zero.
- The display register changes only in LOAD, so a scan never shows a mix of old and new digits.

## Timing
- Reset values:
  - state IDLE, `ready`=1, `done`=0, `ovf`=0.
  - display register 0, prescaler 0, index 0.
  - `an` selects digit 0. `seg` shows "0" (with BLANK_LZ=1 every other digit is blank).
- `seg` and `an` are registered, with one cycle latency from the index/display register.
- Handshake: a transfer occurs on the rising edge where `valor_valid`&&`ready`. The value is sampled at that edge.
- Latency: accept edge t0; CONVERT occupies t1..t32; LOAD at t33 updates the display register and asserts `done` for the cycle after t33. `ready` is low for 33 cycles. The earliest next accept is at t34.
- `valor_valid` held high continuously produces back-to-back loads every 34 cycles.
- Reset mid-CONVERT aborts immediately. The display returns to 0 and no `done` is issued.
- CLK_DIV=1: the index advances every cycle.

## Structure
- Package display7seg_pkg holds:
  - the dec2seg function (digit→base pattern),
  - constants SEG_BLANK and SEG_DASH,
  - the FSM state enum {IDLE, CONVERT, LOAD},
  - the DIGITS=8 constant.
- Sub-module bin_to_bcd_seq contains the iterative double-dabble: the shift register, accumulator, step counter, start/busy/finish signals and the 40-bit result. The top holds the FSM, the display register and the scanner.

## Test plan
- Reset, then idle for 3 cycles → `ready`=1, `ovf`=0, `an` selects digit 0, `seg`=1000000, `done` never pulses.
- Load 12,345,678 with CLK_DIV=4 → `done` pulses 33 cycles after accept. Across 32 cycles of scanning, digits 0..7 show 8,7,6,5,4,3,2,1 with the patterns above, each enabled for 4 cycles.
- Load 99,999,999, then 100,000,000 → first load gives all digits 0010000 and `ovf`=0; second load gives all digits dash and `ovf`=1.
- BLANK_LZ=1, load 305 → digits 0..2 show 5,0,3 and digits 3..7 show 1111111. Load 0 → only digit 0 shows 1000000.
- Pulse `valor_valid` at t5 and t10 after an accept at t0 → the second request is ignored and only one `done` is seen. With `valor_valid` held high, `done` repeats every 34 cycles.
- Assert `rst` at step 15 of a conversion of 4,294,967,295 → no `done`, display shows 0, `ready`=1 on the first cycle after release. COMMON_ANODE=1 run → `seg`/`an` are bitwise inverses of the COMMON_ANODE=0 run.
